cordic_iter_engine: RTL and testbench

Parametrised iterative CORDIC engine that runs a full micro-rotation sequence on one shared shift/add datapath, one iteration per clock. It succeeds the fixed-shift, rotation-only pipeline stages and adds the following:
- width and iteration count as parameters;
- an internal arctangent table;
- rotation and vectoring modes;
- signed arithmetic with guard bits;
- a start/busy/done handshake.

It sits between the angle/vector sources and the downstream sin/cos and magnitude/phase consumers.

---
 rtl/cordic_iter_engine.sv | 132 +++++++++++++
 tb/tb_cordic_iter_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one shift/add micro-rotation per clock, rotation or vectoring mode.
// Define CORDIC_GAIN_COMP_EN to add a gain-compensation cycle (x,y scaled by K ~ 0.60725).
module cordic_iter_engine #(
  parameter int WIDTH = 16,
  parameter int ITERS = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH+1:0] x_out,
  output logic [WIDTH+1:0] y_out,
  output logic [WIDTH-1:0] z_out
);
  localparam int XW = WIDTH + 2;
  localparam int IW = $clog2(ITERS);

  typedef enum logic [1:0] {IDLE, ITER, GAIN, OUT} state_t;

  // atan(2^-i) scaled so that +pi maps to 2^(WIDTH-1); the cast rounds to nearest
  function automatic logic [WIDTH-1:0] atanEntry(input int idx);
    real a;
    a = $atan(2.0 ** (-idx)) / 3.14159265358979323846 * (2.0 ** (WIDTH - 1));
    return WIDTH'(longint'(a));
  endfunction

  logic [WIDTH-1:0] atanTab [ITERS];
  for (genvar g = 0; g < ITERS; g++) begin : g_atan
    localparam logic [WIDTH-1:0] ATAN_G = atanEntry(g);
    assign atanTab[g] = ATAN_G;
  end

  state_t state, nextState;
  logic [IW-1:0] iCnt;
  logic modeReg;
  logic signed [XW-1:0] xReg, yReg, xShr, yShr, xNext, yNext;
  logic signed [WIDTH-1:0] zReg, zNext, atanI;
  logic accept, lastIter, dPos;

`ifdef CORDIC_GAIN_COMP_EN
  localparam state_t LAST_ITER_NEXT = GAIN;
`else
  localparam state_t LAST_ITER_NEXT = OUT;
`endif

  assign accept   = start && ((state == IDLE) || (state == OUT));
  assign lastIter = (iCnt == IW'(ITERS - 1));
  assign busy     = (state == ITER) || (state == GAIN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = ITER;
      ITER:    if (lastIter) nextState = LAST_ITER_NEXT;
      GAIN:    nextState = OUT;
      OUT:     nextState = start ? ITER : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Micro-rotation: d=+1 rotates counter-clockwise and subtracts the table angle
  always_comb begin
    xShr  = xReg >>> iCnt;
    yShr  = yReg >>> iCnt;
    atanI = $signed(atanTab[iCnt]);
    dPos  = modeReg ? yReg[XW-1] : ~zReg[WIDTH-1];
    xNext = dPos ? (xReg - yShr) : (xReg + yShr);
    yNext = dPos ? (yReg + xShr) : (yReg - xShr);
    zNext = dPos ? (zReg - atanI) : (zReg + atanI);
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = 2 * XW;
  localparam logic signed [XW-1:0] KCOEF = XW'(longint'(0.6072529350 * (2.0 ** WIDTH)));
  localparam logic signed [PW-1:0] HALF  = PW'(1) << (WIDTH - 1);
  logic signed [PW-1:0] xProd, yProd;
  logic signed [XW-1:0] xGain, yGain;
  assign xProd = PW'(xReg) * PW'(KCOEF) + HALF;
  assign yProd = PW'(yReg) * PW'(KCOEF) + HALF;
  assign xGain = XW'(xProd >>> WIDTH);
  assign yGain = XW'(yProd >>> WIDTH);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      iCnt    <= '0;
      modeReg <= 1'b0;
      xReg    <= '0;
      yReg    <= '0;
      zReg    <= '0;
      done    <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      z_out   <= '0;
    end else begin
      done <= (state == OUT);
      if (accept) begin
        modeReg <= mode;
        xReg    <= XW'($signed(x_in));
        yReg    <= XW'($signed(y_in));
        zReg    <= $signed(z_in);
        iCnt    <= '0;
      end else if (state == ITER) begin
        xReg <= xNext;
        yReg <= yNext;
        zReg <= zNext;
        iCnt <= lastIter ? '0 : iCnt + 1'b1;
`ifdef CORDIC_GAIN_COMP_EN
      end else if (state == GAIN) begin
        xReg <= xGain;
        yReg <= yGain;
`endif
      end
      // Result registers are loaded from the working set before a back-to-back capture overwrites it
      if (state == OUT) begin
        x_out <= xReg;
        y_out <= yReg;
        z_out <= zReg;
      end
    end
  end
endmodule

// File: tb/tb_cordic_iter_engine.sv
// Scoreboard bench for cordic_iter_engine: expected results come from real-valued trigonometry,
// pushed when a request is driven and popped when done is seen.
module tb_cordic_iter_engine;
  localparam int WIDTH = 16;
  localparam int ITERS = 14;
  localparam real PI = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITERS + 2;
`else
  localparam int LAT = ITERS + 1;
`endif

  typedef struct {
    real xE, yE, zE;
    real tolX, tolY, tolZ;
    int  doneCycle;
  } exp_t;

  logic clk, rst, start, mode, busy, done;
  logic [WIDTH-1:0] x_in, y_in, z_in, z_out;
  logic [WIDTH+1:0] x_out, y_out;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  real gainA;

  cordic_iter_engine #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // Called at a negedge: drives a request and pushes its ideal result
  task automatic applyStimulus(input int x, input int y, input int z, input bit m,
                               input real tx, input real ty, input real tz);
    exp_t e;
    real th;
    x_in = WIDTH'(x); y_in = WIDTH'(y); z_in = WIDTH'(z); mode = m; start = 1'b1;
    if (!m) begin
      th = real'(z) * PI / (2.0 ** (WIDTH - 1));
      e.xE = gainA * (real'(x) * $cos(th) - real'(y) * $sin(th));
      e.yE = gainA * (real'(y) * $cos(th) + real'(x) * $sin(th));
      e.zE = 0.0;
    end else begin
      e.xE = gainA * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      e.yE = 0.0;
      e.zE = real'(z) + $atan2(real'(y), real'(x)) * (2.0 ** (WIDTH - 1)) / PI;
    end
    e.tolX = tx; e.tolY = ty; e.tolZ = tz;
    e.doneCycle = cycle + 1 + LAT;
    sb.push_back(e);
  endtask

  task automatic waitDone(input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(negedge clk);
    compared += 5;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b, required 0", done); end
    if (x_out !== '0) begin mismatched++; $display("[TB] FAIL reset_x: got %0h, required 0", x_out); end
    if (y_out !== '0) begin mismatched++; $display("[TB] FAIL reset_y: got %0h, required 0", y_out); end
    if (z_out !== '0) begin mismatched++; $display("[TB] FAIL reset_z: got %0h, required 0", z_out); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single(input bit m);
    int xs[4], ys[4], zs[4];
    bit got;
    exp_t e;
    if (!m) begin
`ifdef CORDIC_GAIN_COMP_EN
      xs[0] = 16384; ys[0] = 0; zs[0] = -10923;
`else
      xs[0] = 19898; ys[0] = 0; zs[0] = 8192;
`endif
    end else begin
      xs[0] = 16384; ys[0] = 16384; zs[0] = 0;
    end
    for (int k = 1; k < 4; k++) begin
      if (!m) begin
        xs[k] = int'($urandom_range(0, 24000)) - 12000;
        ys[k] = int'($urandom_range(0, 24000)) - 12000;
        zs[k] = int'($urandom_range(0, 32768)) - 16384;
      end else begin
        xs[k] = int'($urandom_range(1000, 20000));
        ys[k] = int'($urandom_range(0, 40000)) - 20000;
        zs[k] = 0;
      end
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(xs[k], ys[k], zs[k], m, (k == 0) ? (m ? 8.0 : 4.0) : 12.0,
                    (k == 0) ? 4.0 : 12.0, (k == 0) ? 3.0 : 4.0);
      @(negedge clk);
      start = 1'b0;
      waitDone(LAT + 5, got);
      e = sb.pop_front();
      compared++;
      if (!got) begin
        mismatched++;
        $display("[TB] FAIL mode%0d_case%0d_done: no done seen, required at cycle %0d", m, k, e.doneCycle);
      end else begin
        compared += 4;
        if (cycle != e.doneCycle) begin mismatched++; $display("[TB] FAIL mode%0d_case%0d_latency: done at cycle %0d, required %0d", m, k, cycle, e.doneCycle); end
        if (absr(real'($signed(x_out)) - e.xE) > e.tolX) begin mismatched++; $display("[TB] FAIL mode%0d_case%0d_x: got %0d, required %0.1f +/- %0.1f", m, k, $signed(x_out), e.xE, e.tolX); end
        if (absr(real'($signed(y_out)) - e.yE) > e.tolY) begin mismatched++; $display("[TB] FAIL mode%0d_case%0d_y: got %0d, required %0.1f +/- %0.1f", m, k, $signed(y_out), e.yE, e.tolY); end
        if (absr(real'($signed(z_out)) - e.zE) > e.tolZ) begin mismatched++; $display("[TB] FAIL mode%0d_case%0d_z: got %0d, required %0.1f +/- %0.1f", m, k, $signed(z_out), e.zE, e.tolZ); end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL mode%0d_case%0d_pulse: done got %b one cycle later, required 0", m, k, done); end
      end
    end
  endtask

  task automatic test_ignore_start();
    int nDone = 0;
    int doneCyc = 0;
    logic [WIDTH+1:0] xs, ys;
    logic [WIDTH-1:0] zs;
    exp_t e;
    applyStimulus(9000, -4000, 5000, 1'b0, 12.0, 12.0, 4.0);
    for (int c = 1; c <= LAT + 6; c++) begin
      @(negedge clk);
      start = (c == 3) || (c == 7);
      if (start) begin
        x_in = WIDTH'(int'($urandom_range(0, 20000)) - 10000);
        y_in = WIDTH'(int'($urandom_range(0, 20000)) - 10000);
        z_in = WIDTH'(-12000);
        mode = c[0];
      end
      if (done === 1'b1) begin
        nDone++;
        if (nDone == 1) begin xs = x_out; ys = y_out; zs = z_out; doneCyc = cycle; end
      end
    end
    e = sb.pop_front();
    compared++;
    if (nDone != 1) begin
      mismatched++;
      $display("[TB] FAIL ignore_done_count: got %0d done pulses, required 1", nDone);
    end else begin
      compared += 4;
      if (doneCyc != e.doneCycle) begin mismatched++; $display("[TB] FAIL ignore_latency: done at cycle %0d, required %0d", doneCyc, e.doneCycle); end
      if (absr(real'($signed(xs)) - e.xE) > e.tolX) begin mismatched++; $display("[TB] FAIL ignore_x: got %0d, required %0.1f", $signed(xs), e.xE); end
      if (absr(real'($signed(ys)) - e.yE) > e.tolY) begin mismatched++; $display("[TB] FAIL ignore_y: got %0d, required %0.1f", $signed(ys), e.yE); end
      if (absr(real'($signed(zs)) - e.zE) > e.tolZ) begin mismatched++; $display("[TB] FAIL ignore_z: got %0d, required %0.1f", $signed(zs), e.zE); end
    end
  endtask

  task automatic test_reset_abort();
    int nDone = 0;
    bit got;
    exp_t e;
    applyStimulus(-7000, 11000, -9000, 1'b0, 12.0, 12.0, 4.0);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    compared += 5;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_done: got %b, required 0", done); end
    if (x_out !== '0) begin mismatched++; $display("[TB] FAIL abort_x: got %0h, required 0", x_out); end
    if (y_out !== '0) begin mismatched++; $display("[TB] FAIL abort_y: got %0h, required 0", y_out); end
    if (z_out !== '0) begin mismatched++; $display("[TB] FAIL abort_z: got %0h, required 0", z_out); end
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      if (done === 1'b1) nDone++;
    end
    compared++;
    if (nDone != 0) begin mismatched++; $display("[TB] FAIL abort_late_done: got %0d done pulses, required 0", nDone); end
    applyStimulus(15000, 6000, 0, 1'b1, 12.0, 12.0, 4.0);
    @(negedge clk);
    start = 1'b0;
    waitDone(LAT + 5, got);
    e = sb.pop_front();
    compared++;
    if (!got) begin
      mismatched++;
      $display("[TB] FAIL abort_fresh_done: no done seen, required at cycle %0d", e.doneCycle);
    end else begin
      compared += 3;
      if (cycle != e.doneCycle) begin mismatched++; $display("[TB] FAIL abort_fresh_latency: done at cycle %0d, required %0d", cycle, e.doneCycle); end
      if (absr(real'($signed(x_out)) - e.xE) > e.tolX) begin mismatched++; $display("[TB] FAIL abort_fresh_x: got %0d, required %0.1f", $signed(x_out), e.xE); end
      if (absr(real'($signed(z_out)) - e.zE) > e.tolZ) begin mismatched++; $display("[TB] FAIL abort_fresh_z: got %0d, required %0.1f", $signed(z_out), e.zE); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    localparam int N = 4;
    fork
      begin
        int x, y, z;
        bit m;
        for (int c = 0; c < N * LAT; c++) begin
          m = 1'(($urandom_range(0, 1)));
          if (m) begin
            x = int'($urandom_range(1000, 20000));
            y = int'($urandom_range(0, 40000)) - 20000;
            z = 0;
          end else begin
            x = int'($urandom_range(0, 24000)) - 12000;
            y = int'($urandom_range(0, 24000)) - 12000;
            z = int'($urandom_range(0, 32768)) - 16384;
          end
          if ((c % LAT) == 0) applyStimulus(x, y, z, m, 12.0, 12.0, 4.0);
          else begin
            x_in = WIDTH'(x); y_in = WIDTH'(y); z_in = WIDTH'(z); mode = m; start = 1'b1;
          end
          @(negedge clk);
        end
        start = 1'b0;
      end
      begin
        bit got;
        exp_t e;
        for (int k = 0; k < N; k++) begin
          waitDone(LAT + 5, got);
          compared++;
          if (!got || sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL b2b%0d_done: no done seen within %0d cycles, required one", k, LAT + 5);
            break;
          end
          e = sb.pop_front();
          compared += 4;
          if (cycle != e.doneCycle) begin mismatched++; $display("[TB] FAIL b2b%0d_latency: done at cycle %0d, required %0d", k, cycle, e.doneCycle); end
          if (absr(real'($signed(x_out)) - e.xE) > e.tolX) begin mismatched++; $display("[TB] FAIL b2b%0d_x: got %0d, required %0.1f", k, $signed(x_out), e.xE); end
          if (absr(real'($signed(y_out)) - e.yE) > e.tolY) begin mismatched++; $display("[TB] FAIL b2b%0d_y: got %0d, required %0.1f", k, $signed(y_out), e.yE); end
          if (absr(real'($signed(z_out)) - e.zE) > e.tolZ) begin mismatched++; $display("[TB] FAIL b2b%0d_z: got %0d, required %0.1f", k, $signed(z_out), e.zE); end
          @(negedge clk);
        end
      end
    join
    sb.delete();
  endtask

  initial begin
`ifdef CORDIC_GAIN_COMP_EN
    gainA = 1.0;
`else
    gainA = 1.0;
    for (int i = 0; i < ITERS; i++) gainA = gainA * $sqrt(1.0 + 2.0 ** (-2 * i));
`endif
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    test_reset();
    test_single(1'b0);
    test_single(1'b1);
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "[TB] timeout");
  end
endmodule
